// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: grants the shared cache-to-DDR port to the instruction or data side,
// counts beats of the granted transaction and closes the port when the burst completes.
module ddr_port_arbiter #(
   parameter int DATA_MAX_BURST        = 4,
   parameter int INSTRUCTION_MAX_BURST = 8,
   parameter int STARVATION_LIMIT      = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       instr_req_i,
   output logic       instr_gnt_o,
   output logic       instr_end_o,
   input  logic       data_req_i,
   input  logic       data_write_i,
   input  logic       data_single_i,
   output logic       data_gnt_o,
   output logic       data_end_o,
   input  logic       ddr_load_valid_i,
   input  logic       ddr_store_done_i,
   output logic       hold_o,
   output logic       instr_sel_o,
   output logic       single_trx_o,
   output logic [1:0] owner_o,
   output logic       busy_o
);
   localparam int MAX_BURST = DATA_MAX_BURST > INSTRUCTION_MAX_BURST ? DATA_MAX_BURST : INSTRUCTION_MAX_BURST;
   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam int SW = $clog2(STARVATION_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, GRANT, BUSY, DRAIN} state_t;
   state_t        state;
   logic [BW-1:0] beat_cnt;
   logic [BW-1:0] beat_target;
   logic [SW-1:0] starve_cnt;
   logic          write;
   logic          data_win;
   logic          beat;
   // A starved instruction request overrides the default data priority.
   assign data_win = data_req_i && !(instr_req_i && starve_cnt == SW'(STARVATION_LIMIT));
   assign beat     = write ? ddr_store_done_i : ddr_load_valid_i;
   assign busy_o   = state != IDLE;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         beat_cnt     <= '0;
         beat_target  <= '0;
         starve_cnt   <= '0;
         write        <= 1'b0;
         hold_o       <= 1'b1;
         owner_o      <= 2'b00;
         instr_sel_o  <= 1'b0;
         single_trx_o <= 1'b0;
         instr_gnt_o  <= 1'b0;
         data_gnt_o   <= 1'b0;
         instr_end_o  <= 1'b0;
         data_end_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (data_req_i || instr_req_i) begin
               state        <= GRANT;
               owner_o      <= data_win ? 2'b10 : 2'b01;
               instr_sel_o  <= !data_win;
               single_trx_o <= data_win && data_single_i;
               write        <= data_win && data_write_i;
               beat_target  <= !data_win ? BW'(INSTRUCTION_MAX_BURST) : data_single_i ? BW'(1) : BW'(DATA_MAX_BURST);
               instr_gnt_o  <= !data_win;
               data_gnt_o   <= data_win;
               // data_win with instr_req_i implies starve_cnt is below the limit, so this saturates
               starve_cnt   <= !data_win ? '0 : instr_req_i ? starve_cnt + 1'b1 : starve_cnt;
            end
            GRANT: begin
               instr_gnt_o <= 1'b0;
               data_gnt_o  <= 1'b0;
               beat_cnt    <= '0;
               hold_o      <= 1'b0;
               state       <= BUSY;
            end
            BUSY: if (beat) begin
               beat_cnt <= beat_cnt + 1'b1;
               if (beat_cnt + 1'b1 == beat_target) begin
                  state       <= DRAIN;
                  hold_o      <= 1'b1;
                  instr_end_o <= instr_sel_o;
                  data_end_o  <= !instr_sel_o;
               end
            end
            DRAIN: begin
               instr_end_o  <= 1'b0;
               data_end_o   <= 1'b0;
               owner_o      <= 2'b00;
               instr_sel_o  <= 1'b0;
               single_trx_o <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Shares the single cache-to-DDR transaction port between the instruction cache and the data cache/uncached data path. It picks one requester, latches the transaction attributes the DDR-side interface needs (`instr_req`, `single_trx`), and opens the port by releasing `hold`. It counts completed beats and then closes the port and signals the end of the transaction to the owner. It sits between the two cache miss controllers and the cache/DDR interface, which consumes `hold_o`, `instr_sel_o` and `single_trx_o`.

## Interface
- `DATA_MAX_BURST`, 4: 32-bit beats per data-cache line transaction.
- `INSTRUCTION_MAX_BURST`, 8: 32-bit beats per instruction-cache line transaction.
- `STARVATION_LIMIT`, 16: consecutive data grants after which a waiting instruction request wins.
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `instr_req_i` in 1: instruction cache line-read request; held high until `instr_gnt_o`.
- `instr_gnt_o` out 1: one-cycle grant pulse to the instruction cache.
- `instr_end_o` out 1: one-cycle pulse when the instruction transaction completes.
- `data_req_i` in 1: data request; held high until `data_gnt_o`.
- `data_write_i` in 1: data transaction is a store (1) or a load (0); sampled with the request.
- `data_single_i` in 1: single-word (uncached) data transaction; sampled with the request.
- `data_gnt_o` out 1: one-cycle grant pulse to the data side.
- `data_end_o` out 1: one-cycle pulse when the data transaction completes.
- `ddr_load_valid_i` in 1: one 32-bit load beat delivered by the DDR interface this cycle.
- `ddr_store_done_i` in 1: one store beat accepted by the DDR interface this cycle.
- `hold_o` out 1: high blocks the DDR interface from starting a transaction.
- `instr_sel_o` out 1: the current transaction is an instruction fetch.
- `single_trx_o` out 1: the current transaction is single-word.
- `owner_o` out 2: current owner; 00 none, 01 instruction, 10 data.
- `busy_o` out 1: the arbiter is not in IDLE.

## Operation
- **FSM states:** IDLE, GRANT, BUSY, DRAIN.
- **IDLE:**
  - Sample the requests.
  - Data has priority.
  - If `instr_req_i` and `starve_cnt == STARVATION_LIMIT`, instruction wins instead.
  - On a win, latch the owner, `instr_sel`, `single_trx` (= `data_single_i` for data, 0 for instruction) and `write` (= `data_write_i` for data, 0 for instruction).
  - Load `beat_target`, then go to GRANT.
- **`beat_target`:**
  - Instruction: `INSTRUCTION_MAX_BURST`.
  - Data, single: 1.
  - Data, line: `DATA_MAX_BURST`.
- **GRANT:**
  - Assert the owner's `*_gnt_o` for exactly this cycle.
  - Clear `beat_cnt`.
  - Go to BUSY.
- **BUSY:**
  - `hold_o` = 0.
  - `beat_cnt` increments on `ddr_store_done_i` when the latched `write` = 1, and on `ddr_load_valid_i` when `write` = 0.
  - The beat on which `beat_cnt + 1 == beat_target` moves the FSM to DRAIN.
- **DRAIN:**
  - `hold_o` = 1.
  - Assert the owner's `*_end_o` for exactly this cycle.
  - Clear the owner, then go to IDLE.
- **`starve_cnt`** (width `$clog2(STARVATION_LIMIT+1)`):
  - Increments, saturating at `STARVATION_LIMIT`, on each data grant while `instr_req_i` = 1.
  - Clears on an instruction grant.
- **Counter width:** `beat_cnt` is `$clog2(max(DATA_MAX_BURST, INSTRUCTION_MAX_BURST))+1` bits; it never wraps because the FSM leaves BUSY at the target.
- **Ignored inputs:**
  - Beat strobes outside BUSY.
  - A beat strobe of the wrong kind (load strobe during a store, store strobe during a load).
  - Requests outside IDLE; they are re-evaluated on return to IDLE.
- **Request timing:** a request is evaluated only in IDLE, so a request that rises in DRAIN is granted the cycle after IDLE evaluates it.
- **Simultaneous requests:** data wins unless starvation is reached.
- **Outputs derived from the latched attributes:**
  - `instr_sel_o` and `single_trx_o` reflect the latched values in GRANT, BUSY and DRAIN.
  - Both are 0 in IDLE.

## Timing
- **Reset values:**
  - FSM in IDLE.
  - `hold_o` = 1.
  - `owner_o` = 00.
  - All other outputs 0.
  - `starve_cnt` and `beat_cnt` = 0.
- **Reset mid-operation:** asserting `rst_i` in any state returns to IDLE immediately (asynchronously) with the reset values; no end pulse is issued.
- **Grant latency:** a request seen high in IDLE at edge N gives `*_gnt_o` high during cycle N+1 and `hold_o` low from cycle N+2.
- **End latency:** the final beat at edge M gives `*_end_o` high and `hold_o` high during cycle M+1, and IDLE from cycle M+2.
- **Back-to-back minimum:** IDLE → GRANT → BUSY(≥1) → DRAIN = 4 cycles per transaction.

## Test plan
- **Instruction fetch alone:** `instr_req_i` = 1 at edge 1 → `instr_gnt_o` pulse in cycle 2, `hold_o` low from cycle 3. Then 8 `ddr_load_valid_i` beats → `instr_end_o` pulse one cycle after the 8th beat, `owner_o` back to 00.
- **Simultaneous requests:** `instr_req_i` and `data_req_i` (load, line) both high → data granted first. After 4 load beats, the instruction is granted on the return to IDLE.
- **Single store:** `data_req_i` = 1, `data_write_i` = 1, `data_single_i` = 1 → `single_trx_o` = 1 during BUSY. One `ddr_store_done_i` → `data_end_o`. Load strobes injected during BUSY do not advance the count.
- **Starvation:** hold `instr_req_i` high and issue continuous data requests → exactly 16 data grants, then the instruction wins and `starve_cnt` returns to 0.
- **Reset mid-burst:** `rst_i` pulsed after 3 of 8 instruction beats → outputs at reset values within the same cycle, no `instr_end_o`, and the next request is granted normally.
